// File: rtl/nco_phase_accumulator.sv
// ---------------------------------------------------------------------------
// nco_phase_accumulator
//
// Phase accumulator for the NCO. It integrates a tuning word once per audio
// sample strobe and presents the accumulator MSBs as the phase word for the
// quarter-wave sine lookup. It also supports note gating, hard sync and an
// exponential glide (portamento) between tuning words.
//
// Ports:
//   clk          system clock (rising edge)
//   rst_n        asynchronous active-low reset
//   sample_en    one-cycle strobe at the audio sample rate
//   tw_in        new tuning word (phase increment), ACC_WIDTH bits
//   tw_valid     tw_in valid
//   tw_ready     block can accept a tuning word (no word pending)
//   glide_en     1 = glide to the new tuning word, 0 = jump to it
//   gate         note on/off, sampled on sample_en
//   sync         hard-sync request, held internally until the next strobe
//   phase        phase word, PHASE_WIDTH MSBs of the accumulator
//   phase_valid  one-cycle pulse, phase updated (one clk after sample_en)
//   wrap         one-cycle pulse, accumulator overflowed on this update
// ---------------------------------------------------------------------------
module nco_phase_accumulator #(
    parameter int ACC_WIDTH   = 24,
    parameter int PHASE_WIDTH = 8,
    parameter int GLIDE_SHIFT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample_en,
    input  logic [ACC_WIDTH-1:0]   tw_in,
    input  logic                   tw_valid,
    output logic                   tw_ready,
    input  logic                   glide_en,
    input  logic                   gate,
    input  logic                   sync,
    output logic [PHASE_WIDTH-1:0] phase,
    output logic                   phase_valid,
    output logic                   wrap
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GLIDE = 2'd2
    } state_t;

    // Registered state
    state_t                 state_reg;
    logic [ACC_WIDTH-1:0]   acc_reg;
    logic [ACC_WIDTH-1:0]   cur_tw_reg;
    logic [ACC_WIDTH-1:0]   tgt_tw_reg;
    logic                   pending_reg;
    logic                   sync_latch_reg;
    logic [PHASE_WIDTH-1:0] phase_reg;
    logic                   phase_valid_reg;
    logic                   wrap_reg;

    // Next-state values, only committed on sample_en
    state_t                 state_next;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic [ACC_WIDTH-1:0]   cur_tw_next;
    logic                   wrap_next;

    // Datapath helpers
    logic                   tw_accept;
    logic                   sync_hit;
    logic                   tgt_above;
    logic [ACC_WIDTH-1:0]   glide_diff;
    logic [ACC_WIDTH-1:0]   glide_shifted;
    logic [ACC_WIDTH-1:0]   glide_step;
    logic [ACC_WIDTH-1:0]   glide_cur;
    logic [ACC_WIDTH:0]     acc_sum;

    assign tw_ready    = !pending_reg;
    assign tw_accept   = tw_valid && !pending_reg;
    // A sync arriving on the strobe cycle itself still counts for that strobe.
    assign sync_hit    = sync_latch_reg || sync;

    assign phase       = phase_reg;
    assign phase_valid = phase_valid_reg;
    assign wrap        = wrap_reg;

    // Glide step: distance scaled down, never below 1 so the glide always
    // terminates. The step never exceeds the distance, so it cannot overshoot.
    assign tgt_above     = tgt_tw_reg > cur_tw_reg;
    assign glide_diff    = tgt_above ? (tgt_tw_reg - cur_tw_reg) : (cur_tw_reg - tgt_tw_reg);
    assign glide_shifted = glide_diff >> GLIDE_SHIFT;
    assign glide_step    = (glide_shifted == '0) ? ACC_WIDTH'(1) : glide_shifted;
    assign glide_cur     = tgt_above ? (cur_tw_reg + glide_step) : (cur_tw_reg - glide_step);

    // Accumulate with the tuning word as it stood before this strobe's update;
    // the extra MSB is the carry that drives wrap.
    assign acc_sum = {1'b0, acc_reg} + {1'b0, cur_tw_reg};

    always_comb begin
        acc_next    = acc_reg;
        cur_tw_next = cur_tw_reg;
        state_next  = state_reg;
        wrap_next   = 1'b0;

        if (!gate) begin
            // Note off overrides everything: park in IDLE with a cleared
            // accumulator. A pending jump still lands so the next note-on
            // starts at the requested pitch.
            state_next = ST_IDLE;
            acc_next   = '0;
            if (pending_reg && !glide_en) begin
                cur_tw_next = tgt_tw_reg;
            end
        end else begin
            // Tuning word update
            if (pending_reg) begin
                if (glide_en) begin
                    // Entering (or retargeting) a glide; tuning word holds
                    // on this strobe and starts moving on the next one.
                    state_next = ST_GLIDE;
                end else begin
                    cur_tw_next = tgt_tw_reg;
                    state_next  = ST_RUN;
                end
            end else if (state_reg == ST_GLIDE) begin
                if (glide_diff == '0) begin
                    state_next = ST_RUN;
                end else begin
                    cur_tw_next = glide_cur;
                    if (glide_cur == tgt_tw_reg) begin
                        state_next = ST_RUN;
                    end
                end
            end else begin
                // RUN stays RUN; IDLE with gate high is a note-on.
                state_next = ST_RUN;
            end

            // Accumulator update; IDLE already holds acc=0, so a note-on
            // strobe naturally starts from zero and adds on the same strobe.
            if (sync_hit) begin
                acc_next = '0;
            end else begin
                acc_next  = acc_sum[ACC_WIDTH-1:0];
                wrap_next = acc_sum[ACC_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            acc_reg         <= '0;
            cur_tw_reg      <= '0;
            tgt_tw_reg      <= '0;
            pending_reg     <= 1'b0;
            sync_latch_reg  <= 1'b0;
            phase_reg       <= '0;
            phase_valid_reg <= 1'b0;
            wrap_reg        <= 1'b0;
        end else begin
            phase_valid_reg <= sample_en;
            wrap_reg        <= sample_en && wrap_next;

            if (sample_en) begin
                state_reg      <= state_next;
                acc_reg        <= acc_next;
                cur_tw_reg     <= cur_tw_next;
                phase_reg      <= acc_next[ACC_WIDTH-1 -: PHASE_WIDTH];
                sync_latch_reg <= 1'b0;
                pending_reg    <= 1'b0;
            end else if (sync) begin
                sync_latch_reg <= 1'b1;
            end

            // Accepting on a strobe cycle (only possible with nothing
            // pending) leaves the new word pending for the next strobe.
            if (tw_accept) begin
                tgt_tw_reg  <= tw_in;
                pending_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nco_phase_accumulator.sv
module tb_nco_phase_accumulator;

    logic        clk;
    logic        rst_n;
    logic        sample_en;
    logic [23:0] tw_in;
    logic        tw_valid;
    logic        tw_ready;
    logic        glide_en;
    logic        gate;
    logic        sync;
    logic [7:0]  phase;
    logic        phase_valid;
    logic        wrap;

    int vectors     = 0;
    int miscompares = 0;

    nco_phase_accumulator #(
        .ACC_WIDTH  (24),
        .PHASE_WIDTH(8),
        .GLIDE_SHIFT(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_en  (sample_en),
        .tw_in      (tw_in),
        .tw_valid   (tw_valid),
        .tw_ready   (tw_ready),
        .glide_en   (glide_en),
        .gate       (gate),
        .sync       (sync),
        .phase      (phase),
        .phase_valid(phase_valid),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    localparam longint unsigned MOD = 64'd1 << 24;

    longint unsigned m_acc, m_cur, m_tgt;
    bit              m_pending, m_sync, m_gliding;
    bit [7:0]        m_phase;
    bit              m_pv, m_wrap;

    function automatic void model_reset();
        m_acc = 0; m_cur = 0; m_tgt = 0;
        m_pending = 0; m_sync = 0; m_gliding = 0;
        m_phase = 0; m_pv = 0; m_wrap = 0;
    endfunction

    function automatic void model_step(bit se, bit tv, logic [23:0] tw, bit ge, bit gt, bit sy);
        bit              accept;
        longint unsigned old_cur, d, step, sum;
        accept = tv && !m_pending;
        m_pv   = se;
        m_wrap = 0;
        if (se) begin
            if (!gt) begin
                m_gliding = 0;
                m_acc     = 0;
                if (m_pending && !ge) m_cur = m_tgt;
            end else begin
                old_cur = m_cur;
                if (m_pending) begin
                    if (ge) m_gliding = 1;
                    else begin
                        m_cur     = m_tgt;
                        m_gliding = 0;
                    end
                end else if (m_gliding) begin
                    d = (m_tgt > m_cur) ? m_tgt - m_cur : m_cur - m_tgt;
                    step = d / 16;
                    if (step == 0) step = 1;
                    if (d != 0) begin
                        if (m_tgt > m_cur) m_cur = m_cur + step;
                        else               m_cur = m_cur - step;
                    end
                    if (m_cur == m_tgt) m_gliding = 0;
                end
                if (m_sync || sy) m_acc = 0;
                else begin
                    sum    = m_acc + old_cur;
                    m_wrap = (sum >= MOD);
                    m_acc  = sum % MOD;
                end
            end
            m_phase   = 8'(m_acc >> 16);
            m_sync    = 0;
            m_pending = 0;
        end else if (sy) begin
            m_sync = 1;
        end
        if (accept) begin
            m_tgt     = longint'(tw);
            m_pending = 1;
        end
    endfunction

    // One clock: drive inputs at a falling edge, step the model for the
    // coming rising edge, then compare at the next falling edge.
    task automatic tick(input bit se, input bit tv, input logic [23:0] tw, input bit sy);
        sample_en = se;
        tw_valid  = tv;
        tw_in     = tw;
        sync      = sy;
        if (tv && !m_pending) $display("tw accepted 0x%06h glide_en=%0b t=%0t", tw, glide_en, $time);
        model_step(se, tv, tw, glide_en, gate, sy);
        @(negedge clk);
        vectors++;
        if (phase !== m_phase) begin
            miscompares++;
            $display("FAIL phase: got %02h expected %02h t=%0t", phase, m_phase, $time);
        end
        vectors++;
        if (phase_valid !== m_pv) begin
            miscompares++;
            $display("FAIL phase_valid: got %b expected %b t=%0t", phase_valid, m_pv, $time);
        end
        vectors++;
        if (wrap !== m_wrap) begin
            miscompares++;
            $display("FAIL wrap: got %b expected %b t=%0t", wrap, m_wrap, $time);
        end
        vectors++;
        if (tw_ready !== !m_pending) begin
            miscompares++;
            $display("FAIL tw_ready: got %b expected %b t=%0t", tw_ready, !m_pending, $time);
        end
    endtask

    task automatic check_outputs_cleared(input string tag);
        vectors++;
        if (phase !== 8'h00 || phase_valid !== 1'b0 || wrap !== 1'b0 || tw_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: got phase=%02h pv=%b wrap=%b ready=%b expected 00/0/0/1",
                     tag, phase, phase_valid, wrap, tw_ready);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; sample_en = 0; tw_valid = 0; tw_in = '0;
        glide_en = 0; gate = 0; sync = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs_cleared("reset_state");
        rst_n = 1'b1;
        tick(0, 0, 24'h0, 0);
    endtask

    task automatic test_ramp();
        int wraps = 0;
        gate = 1; glide_en = 0;
        tick(0, 1, 24'h010000, 0);
        for (int k = 0; k < 513; k++) begin
            tick(1, 0, 24'h0, 0);
            if (wrap === 1'b1) wraps++;
            vectors++;
            if (phase !== 8'(k)) begin
                miscompares++;
                $display("FAIL ramp_phase: strobe %0d got %02h expected %02h", k, phase, 8'(k));
            end
            repeat ($urandom_range(0, 2)) tick(0, 0, 24'h0, 0);
        end
        vectors++;
        if (wraps != 2) begin
            miscompares++;
            $display("FAIL ramp_wrap_count: got %0d expected 2", wraps);
        end
    endtask

    task automatic test_half();
        glide_en = 0;
        tick(0, 1, 24'h800000, 0);
        gate = 0;
        tick(1, 0, 24'h0, 0);
        gate = 1;
        for (int i = 0; i < 8; i++) begin
            tick(1, 0, 24'h0, 0);
            vectors++;
            if (phase !== ((i % 2 == 0) ? 8'h80 : 8'h00) || wrap !== (i % 2 == 1)) begin
                miscompares++;
                $display("FAIL half_alternate: strobe %0d got phase=%02h wrap=%b", i, phase, wrap);
            end
        end
    endtask

    task automatic test_glide();
        logic [23:0] prev;
        bit          done = 0;
        gate = 1; glide_en = 0;
        tick(0, 1, 24'h000100, 0);
        tick(1, 0, 24'h0, 0);
        glide_en = 1;
        tick(0, 1, 24'h001100, 0);
        tick(1, 0, 24'h0, 0);
        tick(1, 0, 24'h0, 0);
        vectors++;
        if (dut.cur_tw_reg !== 24'h000200) begin
            miscompares++;
            $display("FAIL glide_step2: got %06h expected 000200", dut.cur_tw_reg);
        end
        tick(1, 0, 24'h0, 0);
        vectors++;
        if (dut.cur_tw_reg !== 24'h0002F0) begin
            miscompares++;
            $display("FAIL glide_step3: got %06h expected 0002f0", dut.cur_tw_reg);
        end
        for (int i = 0; i < 400 && !done; i++) begin
            prev = dut.cur_tw_reg;
            tick(1, 0, 24'h0, 0);
            vectors++;
            if (dut.cur_tw_reg !== 24'(m_cur) || dut.cur_tw_reg < prev) begin
                miscompares++;
                $display("FAIL glide_track: got %06h expected %06h prev %06h", dut.cur_tw_reg, 24'(m_cur), prev);
            end
            if (!m_gliding) begin
                done = 1;
                vectors++;
                if (dut.cur_tw_reg - prev !== 24'd1) begin
                    miscompares++;
                    $display("FAIL glide_last_step: got %0d expected 1", dut.cur_tw_reg - prev);
                end
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL glide_timeout: glide did not finish within 400 strobes");
        end
        tick(1, 0, 24'h0, 0);
        vectors++;
        if (dut.cur_tw_reg !== 24'h001100) begin
            miscompares++;
            $display("FAIL glide_final: got %06h expected 001100", dut.cur_tw_reg);
        end
        glide_en = 0;
    endtask

    task automatic test_handshake();
        glide_en = 0;
        tick(0, 1, 24'h020000, 0);
        tick(0, 1, 24'h020000, 0);
        tick(0, 1, 24'h020000, 0);
        vectors++;
        if (tw_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL handshake_hold: got tw_ready=%b expected 0", tw_ready);
        end
        tick(1, 0, 24'h0, 0);
        vectors++;
        if (tw_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL handshake_release: got tw_ready=%b expected 1", tw_ready);
        end
    endtask

    task automatic test_sync_gate();
        gate = 0;
        tick(1, 0, 24'h0, 0);
        gate = 1; glide_en = 0;
        tick(0, 1, 24'h010000, 0);
        for (int i = 0; i < 300 && phase !== 8'h5A; i++) tick(1, 0, 24'h0, 0);
        vectors++;
        if (phase !== 8'h5A) begin
            miscompares++;
            $display("FAIL sync_setup: got phase=%02h expected 5a", phase);
        end
        tick(0, 0, 24'h0, 0);
        tick(0, 0, 24'h0, 1);
        tick(0, 0, 24'h0, 0);
        tick(1, 0, 24'h0, 0);
        vectors++;
        if (phase !== 8'h00 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL sync_clear: got phase=%02h wrap=%b expected 00/0", phase, wrap);
        end
        tick(1, 0, 24'h0, 1);
        tick(1, 0, 24'h0, 0);
        gate = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1, 0, 24'h0, 0);
            tick(0, 0, 24'h0, 0);
            vectors++;
            if (phase !== 8'h00) begin
                miscompares++;
                $display("FAIL gate_off: got phase=%02h expected 00", phase);
            end
        end
        gate = 1;
    endtask

    task automatic test_random();
        logic [23:0] tw;
        for (int i = 0; i < 3000; i++) begin
            glide_en = ($urandom_range(0, 1) == 1);
            gate     = ($urandom_range(0, 9) != 0);
            tw       = ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'($urandom_range(0, 24'h00FFFF));
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, tw, $urandom_range(0, 19) == 0);
        end
        sync = 0;
        tick(1, 0, 24'h0, 0);
    endtask

    task automatic test_reset_mid();
        gate = 1; glide_en = 0;
        tick(0, 1, 24'h300000, 0);
        tick(1, 0, 24'h0, 0);
        tick(1, 0, 24'h0, 0);
        glide_en = 1;
        tick(0, 1, 24'h380000, 0);
        tick(1, 0, 24'h0, 0);
        tick(1, 0, 24'h0, 0);
        tick(1, 1, 24'h100000, 0);
        #2 rst_n = 1'b0;
        tw_valid = 1'b1;
        model_reset();
        #1 check_outputs_cleared("reset_mid_immediate");
        repeat (2) @(negedge clk);
        check_outputs_cleared("reset_mid_held");
        tw_valid = 1'b0;
        rst_n    = 1'b1;
        glide_en = 0;
        tick(0, 0, 24'h0, 0);
        tick(1, 0, 24'h0, 0);
        vectors++;
        if (phase !== 8'h00 || phase_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_first_strobe: got phase=%02h pv=%b expected 00/1", phase, phase_valid);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_half();
        test_glide();
        test_handshake();
        test_sync_gate();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish, got no end expected end");
        $fatal(1, "timeout");
    end

endmodule
